nbit_cpu: RTL and testbench

Parametrised multi-bit successor to the team's one-bit teaching CPU. It has a DATA_W-bit accumulator, a PC_W-bit program counter and an 8-opcode ISA with immediate operands. It fetches from a switch-driven program bus and runs a FETCH/EXEC/HALT state machine advanced by an external slow tick, with run/pause control. It sits between the board's clock divider (tick source) and switches on the input side and the LED display on the output side.

---
 rtl/nbit_cpu_pkg.sv | 23 ++
 rtl/nbit_alu.sv | 41 ++++
 rtl/nbit_cpu.sv | 139 +++++++++++++
 tb/tb_nbit_cpu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nbit_cpu_pkg.sv
// nbit_cpu_pkg: shared opcode and FSM state types for the n-bit teaching CPU.
package nbit_cpu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 3'b000,
      OP_LDI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_XOR = 3'b100,
      OP_JMP = 3'b101,
      OP_JZ  = 3'b110,
      OP_HLT = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/nbit_alu.sv
// nbit_alu: combinational execute unit. Produces the accumulator and carry
// values an instruction would write, plus whether a jump is taken. Carry is
// only changed by ADD and SUB; for SUB it holds the borrow.
module nbit_alu
   import nbit_cpu_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  opcode_t           op,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] imm,
   input  logic              carry,
   output logic [DATA_W-1:0] acc_next,
   output logic              carry_next,
   output logic              jump_taken
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // One extra bit so the top bit is the carry out / borrow out.
   assign sum  = {1'b0, acc} + {1'b0, imm};
   assign diff = {1'b0, acc} - {1'b0, imm};

   // Opcode decode: default is "no architectural change".
   always_comb begin
      acc_next   = acc;
      carry_next = carry;
      jump_taken = 1'b0;
      case (op)
         OP_LDI: acc_next = imm;
         OP_ADD: {carry_next, acc_next} = sum;
         OP_SUB: {carry_next, acc_next} = diff;
         OP_XOR: acc_next = acc ^ imm;
         OP_JMP: jump_taken = 1'b1;
         OP_JZ:  jump_taken = (acc == '0);
         default: ;
      endcase
   end

endmodule

// File: rtl/nbit_cpu.sv
// nbit_cpu: DATA_W-bit accumulator CPU with a PC_W-bit program counter,
// fetching from a switch-driven program bus. Each instruction takes a FETCH
// advance and an EXEC advance; HLT parks the core in HALT until reset.
// The program bus port is named program_bus because "program" is a reserved
// word in SystemVerilog.
// Optional feature macro: NBIT_CPU_STEP_EN adds a push-button step input that
// runs exactly one instruction per debounced-free rising edge.
module nbit_cpu
   import nbit_cpu_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int PC_W   = 3
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    tick,
   input  logic                                    run,
`ifdef NBIT_CPU_STEP_EN
   input  logic                                    step,
`endif
   input  logic [(2**PC_W)*(OP_W+DATA_W)-1:0]      program_bus,
   output logic [DATA_W-1:0]                       acc,
   output logic [PC_W-1:0]                         pc,
   output logic                                    carry,
   output logic                                    halted,
   output logic                                    fetch_led
);

   localparam int IW = OP_W + DATA_W;

   state_t            state;
   state_t            state_next;
   logic [IW-1:0]     ir;
   logic [IW-1:0]     fetch_word;
   opcode_t           op;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] acc_next;
   logic              carry_next;
   logic              jump_taken;
   logic [PC_W-1:0]   target;
   logic              adv;

`ifdef NBIT_CPU_STEP_EN
   // step_sync[1:0] is the two-flop synchroniser, step_sync[2] the delayed
   // copy used for rising-edge detection.
   logic [2:0] step_sync;
   logic       step_edge;
   // step_hold: 3 = FETCH done, EXEC due next; 2..1 = cool-down covering the
   // synchroniser depth so presses made while the instruction was in flight
   // are discarded; 0 = idle, ready for a new press.
   logic [1:0] step_hold;

   assign step_edge = step_sync[1] & ~step_sync[2];

   // Synchronise the push-button and sequence the FETCH/EXEC pair of a step.
   always_ff @(posedge clock) begin
      if (reset) begin
         step_sync <= '0;
         step_hold <= '0;
      end else begin
         step_sync <= {step_sync[1:0], step};
         if (run) begin
            if (step_hold != 2'd0)
               step_hold <= step_hold - 2'd1;
            else if (step_edge)
               step_hold <= 2'd3;
         end
      end
   end

   assign adv = run & (tick | (step_edge & (step_hold == 2'd0)) | (step_hold == 2'd3));
`else
   assign adv = tick & run;
`endif

   assign fetch_word = program_bus[int'(pc)*IW +: IW];
   assign op         = opcode_t'(ir[IW-1 -: OP_W]);
   assign imm        = ir[DATA_W-1:0];
   assign target     = imm[PC_W-1:0];
   assign halted     = (state == HALT);
   assign fetch_led  = (state == FETCH);

   nbit_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op         (op),
      .acc        (acc),
      .imm        (imm),
      .carry      (carry),
      .acc_next   (acc_next),
      .carry_next (carry_next),
      .jump_taken (jump_taken)
   );

   // FSM state register; reset wins over any advance on the same edge.
   always_ff @(posedge clock) begin
      if (reset)
         state <= FETCH;
      else
         state <= state_next;
   end

   // Next-state logic: only an advance moves the FSM; HALT is absorbing.
   always_comb begin
      state_next = state;
      case (state)
         FETCH: if (adv) state_next = EXEC;
         EXEC:  if (adv) state_next = (op == OP_HLT) ? HALT : FETCH;
         HALT:  state_next = HALT;
         default: state_next = FETCH;
      endcase
   end

   // Architectural state: latch the instruction on FETCH, commit it on EXEC.
   always_ff @(posedge clock) begin
      if (reset) begin
         ir    <= '0;
         acc   <= '0;
         pc    <= '0;
         carry <= 1'b0;
      end else if (adv) begin
         case (state)
            FETCH: ir <= fetch_word;
            EXEC: begin
               acc   <= acc_next;
               carry <= carry_next;
               if (op != OP_HLT) begin
                  if (jump_taken)
                     pc <= target;
                  else
                     pc <= pc + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nbit_cpu.sv
// tb_nbit_cpu: self-checking bench for nbit_cpu (DATA_W=4, PC_W=3) with a
// behavioural instruction-level model compared every cycle, directed
// programs with literal expectations, and randomized programs/controls.
module tb_nbit_cpu;

   localparam int DW    = 4;
   localparam int PW    = 3;
   localparam int IW    = 7;
   localparam int DEPTH = 8;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                tick  = 1'b0;
   logic                run   = 1'b1;
   logic [DEPTH*IW-1:0] prog  = '0;
   logic [DW-1:0]       acc;
   logic [PW-1:0]       pc;
   logic                carry;
   logic                halted;
   logic                fetch_led;
`ifdef NBIT_CPU_STEP_EN
   logic                step = 1'b0;
`endif

   nbit_cpu #(.DATA_W(DW), .PC_W(PW)) dut (
      .clock       (clock),
      .reset       (reset),
      .tick        (tick),
      .run         (run),
`ifdef NBIT_CPU_STEP_EN
      .step        (step),
`endif
      .program_bus (prog),
      .acc         (acc),
      .pc          (pc),
      .carry       (carry),
      .halted      (halted),
      .fetch_led   (fetch_led)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b1;

   // Model: phase 0 = waiting to fetch, 1 = waiting to execute, 2 = halted.
   int m_acc = 0, m_pc = 0, m_carry = 0, m_phase = 0, m_ir = 0;

   function automatic int word_at(int a);
      logic [IW-1:0] w;
      w = prog[a*IW +: IW];
      return int'(w);
   endfunction

   task automatic model_step();
      int op, imm, s;
      if (m_phase == 0) begin
         m_ir    = word_at(m_pc);
         m_phase = 1;
      end else if (m_phase == 1) begin
         op  = m_ir / 16;
         imm = m_ir % 16;
         m_phase = 0;
         case (op)
            1: m_acc = imm;
            2: begin s = m_acc + imm; m_carry = (s > 15) ? 1 : 0; m_acc = s % 16; end
            3: begin s = m_acc - imm; m_carry = (s < 0) ? 1 : 0; m_acc = (s + 16) % 16; end
            4: m_acc = m_acc ^ imm;
            default: ;
         endcase
         if (op == 7)
            m_phase = 2;
         else if (op == 5 || (op == 6 && m_acc == 0))
            m_pc = imm % DEPTH;
         else
            m_pc = (m_pc + 1) % DEPTH;
      end
   endtask

   // Advance the model on every rising edge, then compare just after it.
   always @(posedge clock) begin
      if (reset) begin
         m_acc = 0; m_pc = 0; m_carry = 0; m_phase = 0; m_ir = 0;
      end else if (tick && run) begin
         model_step();
      end
      #1;
      if (check_en) begin
         total++;
         if (acc !== m_acc[DW-1:0] || pc !== m_pc[PW-1:0] || carry !== m_carry[0] ||
             halted !== (m_phase == 2) || fetch_led !== (m_phase == 0)) begin
            bad++;
            $display("FAIL cycle t=%0t: got acc=%0d pc=%0d carry=%0b halted=%0b fetch=%0b, want acc=%0d pc=%0d carry=%0d halted=%0b fetch=%0b",
                     $time, acc, pc, carry, halted, fetch_led,
                     m_acc, m_pc, m_carry, m_phase == 2, m_phase == 0);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic set_word(input int a, input int op, input int imm);
      prog[a*IW +: IW] = IW'(op * 16 + imm);
   endtask

   task automatic rand_prog();
      for (int i = 0; i < DEPTH; i++)
         prog[i*IW +: IW] = IW'($urandom_range(0, 127));
   endtask

   // Called at a falling edge; one reset edge, returns at the next falling edge.
   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      tick  = 1'b0;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) @(negedge clock);
      tick = 1'b0;
   endtask

   int s_acc, s_pc, s_carry;

   initial begin
      @(negedge clock);

      // Reset with random program and tick active.
      rand_prog();
      tick = 1'b1;
      do_reset();
      chk("reset_acc", acc, 0);
      chk("reset_pc", pc, 0);
      chk("reset_carry", carry, 0);
      chk("reset_halted", halted, 0);
      chk("reset_fetch_led", fetch_led, 1);

      // LDI 5, ADD 3, HLT.
      prog = '0;
      set_word(0, 1, 5); set_word(1, 2, 3); set_word(2, 7, 0);
      do_reset();
      ticks(6);
      chk("add_acc", acc, 8);
      chk("add_carry", carry, 0);
      chk("add_pc", pc, 2);
      chk("add_halted", halted, 1);
      chk("model_acc_pin", m_acc, 8);
      ticks(5);
      chk("halt_acc", acc, 8);
      chk("halt_pc", pc, 2);
      chk("halt_halted", halted, 1);

      // LDI 15, ADD 1, JZ 5, ..., word5 = SUB 1.
      prog = '0;
      set_word(0, 1, 15); set_word(1, 2, 1); set_word(2, 6, 5);
      set_word(3, 7, 0);  set_word(4, 7, 0); set_word(5, 3, 1); set_word(6, 7, 0);
      do_reset();
      ticks(4);
      chk("wrap_add_acc", acc, 0);
      chk("wrap_add_carry", carry, 1);
      ticks(2);
      chk("jz_pc", pc, 5);
      ticks(2);
      chk("sub_acc", acc, 15);
      chk("sub_borrow", carry, 1);
      chk("sub_pc", pc, 6);

      // All NOP: PC wraps.
      prog = '0;
      do_reset();
      ticks(8);
      chk("nop_pc_mid", pc, 4);
      ticks(8);
      chk("nop_pc_wrap", pc, 0);
      chk("nop_acc", acc, 0);

      // Pause for 10 ticks mid-program.
      prog = '0;
      set_word(0, 1, 3); set_word(1, 2, 4); set_word(2, 4, 6); set_word(3, 5, 0);
      do_reset();
      ticks(3);
      s_acc = m_acc; s_pc = m_pc; s_carry = m_carry;
      run = 1'b0;
      ticks(10);
      chk("pause_acc", acc, s_acc);
      chk("pause_pc", pc, s_pc);
      chk("pause_fetch_led", fetch_led, 0);
      run = 1'b1;
      ticks(5);
      chk("resume_acc", acc, 1);

      // Reset on the EXEC edge together with tick.
      prog = '0;
      set_word(0, 1, 9);
      do_reset();
      ticks(1);
      chk("pre_reset_fetch_led", fetch_led, 0);
      reset = 1'b1; tick = 1'b1;
      @(negedge clock);
      reset = 1'b0; tick = 1'b0;
      chk("exec_reset_acc", acc, 0);
      chk("exec_reset_pc", pc, 0);
      chk("exec_reset_fetch_led", fetch_led, 1);
      ticks(2);
      chk("post_reset_acc", acc, 9);

      // Randomized programs and control.
      for (int r = 0; r < 12; r++) begin
         rand_prog();
         do_reset();
         for (int c = 0; c < 200; c++) begin
            tick  = ($urandom_range(0, 2) != 0);
            run   = ($urandom_range(0, 4) != 0);
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) rand_prog();
            @(negedge clock);
         end
         reset = 1'b0; tick = 1'b0; run = 1'b1;
      end

`ifdef NBIT_CPU_STEP_EN
      // Single-step: LDI 9 then LDI 3; second press inside the window dropped.
      check_en = 1'b0;
      prog = '0;
      set_word(0, 1, 9); set_word(1, 1, 3);
      tick = 1'b0; run = 1'b1;
      do_reset();
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      @(negedge clock);
      step = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("step_acc", acc, 9);
      chk("step_pc", pc, 1);
      step = 1'b0;
      repeat (8) @(negedge clock);
      chk("step_drop_acc", acc, 9);
      chk("step_drop_pc", pc, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
